// File: rtl/digit_serial_adder.sv
// digit_serial_adder: WIDTH-bit a + b + cin computed DIGIT bits per clock on one reused slice.
// Latency: accept in cycle 0, out_valid in cycle N+1 (N = WIDTH/DIGIT); one op per N+2 cycles.
// Backpressure: DONE holds sum/cout/ovf stable until out_ready; in_ready low while busy.
// Optional subtract mode (a - b, sub port) when DIGIT_SERIAL_ADDER_SUB_EN is defined.
// WIDTH must be a multiple of DIGIT, with 1 <= DIGIT <= WIDTH.
module digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  // Number of digits per operand and a counter wide enough to hold N itself.
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             c_q;
  logic [CW-1:0]    cnt_q;
  logic             cout_q, ovf_q;
  logic             in_ready_q, out_valid_q, busy_q;

  // Slice results and next-state values of the shift registers.
  logic [DIGIT:0]   slice_full;
  logic [DIGIT-1:0] slice_s;
  logic             slice_c;
  logic             msb_cin;
  logic [WIDTH-1:0] a_d, b_d, sum_d;
  logic [CW-1:0]    cnt_d;
  logic             last_digit;

  // Operand values captured at the input handshake (B optionally inverted).
  logic [WIDTH-1:0] b_load;
  logic             c_load;

`ifdef DIGIT_SERIAL_ADDER_SUB_EN
  // Subtraction is a + ~b + 1, so the inversion and forced carry happen at load time.
  always_comb begin
    b_load = sub ? ~b : b;
    c_load = sub ? 1'b1 : cin;
  end
`else
  // Addition only: operands pass straight into the shift registers.
  always_comb begin
    b_load = b;
    c_load = cin;
  end
`endif

  // One DIGIT-wide adder slice working on the low digit of each shift register.
  always_comb begin
    slice_full = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, c_q};
    slice_s    = slice_full[DIGIT-1:0];
    slice_c    = slice_full[DIGIT];
    // Carry into the slice MSB recovered from its sum bit; for DIGIT=1 this equals c_q.
    msb_cin    = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ slice_s[DIGIT-1];
  end

  // Shift operands right by one digit; the new digit enters the sum register at the MSB end.
  always_comb begin
    a_d        = a_q >> DIGIT;
    b_d        = b_q >> DIGIT;
    sum_d      = (sum_q >> DIGIT) | (WIDTH'(slice_s) << (WIDTH - DIGIT));
    cnt_d      = cnt_q + CW'(1);
    last_digit = (cnt_q == CW'(N - 1));
  end

  // Control FSM and datapath registers; all outputs come straight from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      c_q         <= 1'b0;
      cnt_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= a;
            b_q        <= b_load;
            c_q        <= c_load;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end
        end
        RUN: begin
          a_q   <= a_d;
          b_q   <= b_d;
          sum_q <= sum_d;
          c_q   <= slice_c;
          cnt_q <= cnt_d;
          if (last_digit) begin
            // Flags are only meaningful on the digit holding bit WIDTH-1.
            cout_q      <= slice_c;
            ovf_q       <= msb_cin ^ slice_c;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          // No pass-through: in_ready rises only after the result has left.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: three instances (DIGIT 4, 1, 16) share stimulus,
// results are compared with plain-arithmetic expectations, latency counted per instance.
module tb_digit_serial_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         cin;
  logic         out_ready;
  logic [W-1:0] a, b;
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
  logic         sub;
`endif

  logic         ir [3];
  logic         ov [3];
  logic         co [3];
  logic         of [3];
  logic         bz [3];
  logic [W-1:0] sm [3];

  int    checks   = 0;
  int    failures = 0;
  int    lat_exp [3] = '{5, 17, 2};
  string nm [3]      = '{"D4", "D1", "D16"};

  always #5 clk = ~clk;

  digit_serial_adder #(.WIDTH(W), .DIGIT(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]),
    .a(a), .b(b), .cin(cin),
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .out_valid(ov[0]), .out_ready(out_ready), .sum(sm[0]),
    .cout(co[0]), .ovf(of[0]), .busy(bz[0]));

  digit_serial_adder #(.WIDTH(W), .DIGIT(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]),
    .a(a), .b(b), .cin(cin),
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .out_valid(ov[1]), .out_ready(out_ready), .sum(sm[1]),
    .cout(co[1]), .ovf(of[1]), .busy(bz[1]));

  digit_serial_adder #(.WIDTH(W), .DIGIT(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]),
    .a(a), .b(b), .cin(cin),
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .out_valid(ov[2]), .out_ready(out_ready), .sum(sm[2]),
    .cout(co[2]), .ovf(of[2]), .busy(bz[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Arithmetic meaning of the operation, independent of how it is computed serially.
  task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                       input logic ts, output logic [W-1:0] es, output logic ec,
                       output logic eo);
    logic [W:0] full;
    if (ts) begin
      full = {1'b0, ta} - {1'b0, tb};
      es   = full[W-1:0];
      ec   = (ta >= tb);
      eo   = (ta[W-1] != tb[W-1]) && (es[W-1] != ta[W-1]);
    end else begin
      full = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
      es   = full[W-1:0];
      ec   = full[W];
      eo   = (ta[W-1] == tb[W-1]) && (es[W-1] != ta[W-1]);
    end
  endtask

  task automatic wait_all_ready(input string tag);
    int k;
    k = 0;
    while (!(ir[0] && ir[1] && ir[2]) && k < 60) begin
      tick();
      k++;
    end
    chk($sformatf("%s:all_ready", tag), {31'b0, ir[0] & ir[1] & ir[2]}, 32'd1);
  endtask

  task automatic reset_vals(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s:%s:in_ready", tag, nm[i]),  {31'b0, ir[i]}, 32'd1);
      chk($sformatf("%s:%s:out_valid", tag, nm[i]), {31'b0, ov[i]}, 32'd0);
      chk($sformatf("%s:%s:busy", tag, nm[i]),      {31'b0, bz[i]}, 32'd0);
      chk($sformatf("%s:%s:sum", tag, nm[i]),       {16'b0, sm[i]}, 32'd0);
      chk($sformatf("%s:%s:cout", tag, nm[i]),      {31'b0, co[i]}, 32'd0);
      chk($sformatf("%s:%s:ovf", tag, nm[i]),       {31'b0, of[i]}, 32'd0);
    end
  endtask

  // One operation through all three instances with out_ready held high.
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tc, input logic ts);
    logic [W-1:0] es;
    logic         ec, eo;
    int           lat [3];
    logic [W-1:0] vs [3];
    logic         vc [3];
    logic         vo [3];
    logic         rdy_after [3];
    logic         busy_ok [3];
    model(ta, tb, tc, ts, es, ec, eo);
    wait_all_ready(tag);
    for (int i = 0; i < 3; i++) begin
      lat[i] = -1; vs[i] = '0; vc[i] = 1'b0; vo[i] = 1'b0;
      rdy_after[i] = 1'b0; busy_ok[i] = 1'b1;
    end
    out_ready = 1'b1;
    a = ta; b = tb; cin = tc;
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    sub = ts;
`endif
    in_valid = 1'b1;
    for (int cyc = 1; cyc <= 18; cyc++) begin
      tick();
      if (cyc == 1) begin
        in_valid = 1'b0;
        a   = W'($urandom);
        b   = W'($urandom);
        cin = 1'($urandom);
      end
      for (int i = 0; i < 3; i++) begin
        if (lat[i] < 0) begin
          if (ov[i]) begin
            lat[i] = cyc; vs[i] = sm[i]; vc[i] = co[i]; vo[i] = of[i];
          end else if (ir[i] || !bz[i]) begin
            busy_ok[i] = 1'b0;
          end
        end else if (cyc == lat[i] + 1) begin
          rdy_after[i] = ir[i] && !ov[i];
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s:%s:latency", tag, nm[i]), lat[i], lat_exp[i]);
      chk($sformatf("%s:%s:sum", tag, nm[i]), {16'b0, vs[i]}, {16'b0, es});
      chk($sformatf("%s:%s:cout", tag, nm[i]), {31'b0, vc[i]}, {31'b0, ec});
      chk($sformatf("%s:%s:ovf", tag, nm[i]), {31'b0, vo[i]}, {31'b0, eo});
      chk($sformatf("%s:%s:busy_in_run", tag, nm[i]), {31'b0, busy_ok[i]}, 32'd1);
      chk($sformatf("%s:%s:ready_after_hs", tag, nm[i]), {31'b0, rdy_after[i]}, 32'd1);
    end
  endtask

  initial begin
    logic [W-1:0] es, ra, rb;
    logic         ec, eo, rc, rs, bad;
    int           k;

    rst = 1'b0; in_valid = 1'b0; cin = 1'b0; out_ready = 1'b1; a = '0; b = '0;
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    #1 rst = 1'b1;
    tick();
    tick();
    reset_vals("reset");
    rst = 1'b0;
    tick();

    // Directed vectors, including all-ones wrap and signed overflow.
    run_op("t1_basic", 16'h1234, 16'h4321, 1'b0, 1'b0);
    run_op("t2_wrap",  16'hFFFF, 16'h0000, 1'b1, 1'b0);
    run_op("t2_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0);
    run_op("t5_sweep", 16'hA5A5, 16'h5A5B, 1'b0, 1'b0);

    // Backpressure: hold DONE for 10 cycles while a competing operand is offered.
    wait_all_ready("t3");
    model(16'h1111, 16'h2222, 1'b0, 1'b0, es, ec, eo);
    out_ready = 1'b0;
    a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
    k = 0; bad = 1'b0;
    do begin
      tick();
      k++;
      if (k == 1) begin
        a = 16'hDEAD; b = 16'hBEEF; cin = 1'b1;
      end
      if (!ov[0] && ir[0]) bad = 1'b1;
    end while (!ov[0] && k < 20);
    chk("t3:latency", k, 32'd5);
    chk("t3:in_ready_low_in_run", {31'b0, bad}, 32'd0);
    for (int h = 0; h < 10; h++) begin
      chk("t3:hold_out_valid", {31'b0, ov[0]}, 32'd1);
      chk("t3:hold_sum", {16'b0, sm[0]}, {16'b0, es});
      chk("t3:hold_cout", {31'b0, co[0]}, {31'b0, ec});
      chk("t3:hold_ovf", {31'b0, of[0]}, {31'b0, eo});
      chk("t3:hold_in_ready", {31'b0, ir[0]}, 32'd0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("t3:released_out_valid", {31'b0, ov[0]}, 32'd0);
    chk("t3:released_in_ready", {31'b0, ir[0]}, 32'd1);

    // Reset during the second RUN cycle discards the operation.
    wait_all_ready("t4");
    a = 16'h00FF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    reset_vals("t4_midrun");
    tick();
    rst = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (ov[0] || ov[1] || ov[2]) bad = 1'b1;
    end
    chk("t4:no_output_after_reset", {31'b0, bad}, 32'd0);
    run_op("t4_after", 16'h0002, 16'h0003, 1'b0, 1'b0);

`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    run_op("t6_sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1);
    run_op("t6_sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1);
`endif

    // Randomized operations, biased towards sign and carry edges.
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 3))
        0: ra = 16'hFFFF;
        1: ra = 16'h8000;
        default: ra = W'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0: rb = 16'h7FFF;
        1: rb = 16'h0001;
        default: rb = W'($urandom);
      endcase
      rc = 1'($urandom);
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      run_op($sformatf("rand%0d", n), ra, rb, rc, rs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/digit_serial_adder.md
Name: digit_serial_adder

Overview:
- Parametrised successor of the team's 1-bit full-adder cell. Adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, by reusing one DIGIT-wide adder slice over WIDTH/DIGIT cycles.
- Valid/ready handshakes on input and output. Reports carry-out and signed overflow.
- Sits between the operand registers and the result bus of the small arithmetic datapath. Trades latency for area.

Parameters:
WIDTH  16  operand/result width in bits; must be a multiple of DIGIT
DIGIT  4   bits added per cycle; 1 <= DIGIT <= WIDTH (DIGIT=1 gives a pure bit-serial adder)

Ports:
clk        input   1      clock, all state on rising edge
rst        input   1      asynchronous, active-high reset
in_valid   input   1      operands a, b, cin valid
in_ready   output  1      block can accept operands
a          input   WIDTH  operand A
b          input   WIDTH  operand B
cin        input   1      carry-in
out_valid  output  1      result valid
out_ready  input   1      consumer accepts result
sum        output  WIDTH  a + b + cin, modulo 2^WIDTH
cout       output  1      carry out of bit WIDTH-1
ovf        output  1      two's-complement signed overflow
busy       output  1      high in RUN or DONE

Behaviour:
- Decided interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values:
  - State is IDLE.
  - in_ready=1, out_valid=0, busy=0.
  - sum=0, cout=0, ovf=0.
  - Internal operand shift registers, carry register and digit counter are all 0.
- Derived constant N = WIDTH/DIGIT. The digit counter is ceil(log2(N+1)) bits wide.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: latch a and b into shift registers, load the carry register with cin, clear the counter, go to RUN.
- RUN:
  - in_ready=0. in_valid and operand inputs are ignored.
  - Each cycle, add the low DIGIT bits of the A and B shift registers plus the carry register.
  - The DIGIT-bit result shifts into the sum register from the MSB end (sum register shifts right by DIGIT).
  - The A and B shift registers shift right by DIGIT. The carry register takes the slice carry-out.
  - The counter increments. After the N-th digit (counter reaches N-1 in that cycle), go to DONE.
- On the final digit only:
  - cout = slice carry-out.
  - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - When DIGIT=1, the carry into the MSB is the carry register value.
- DONE:
  - out_valid=1. sum, cout and ovf are stable and hold until the handshake.
  - On out_valid && out_ready: go to IDLE. in_ready rises the next cycle; there is no same-cycle pass-through.
- Latency: accept in cycle 0 → out_valid high in cycle N+1. Throughput is one operation per N+2 cycles when out_ready is held high.
- sum is only valid while out_valid=1. While in RUN it shows partial shift contents; the verifier must not check it then.
- Backpressure: DONE holds indefinitely while out_ready=0. Outputs must not change.
- in_valid asserted while busy: ignored, no corruption. The source must hold it until in_ready.
- Reset asserted mid-RUN or in DONE: immediate return to the reset values. The pending operation is discarded with no output.
- Boundary cases:
  - DIGIT=WIDTH (N=1): a single RUN cycle.
  - Operand all-ones plus cin=1 wraps to 0 with cout=1.

Optional Feature:
- Macro: DIGIT_SERIAL_ADDER_SUB_EN.
- When defined:
  - Adds input port sub (1 bit), sampled with the operands at the input handshake.
  - sub=1 computes a - b: B is inverted as it is latched, and the carry register loads 1 (cin is ignored).
  - cout=1 means no borrow (a >= b unsigned).
  - ovf is the signed subtraction overflow, computed by the same MSB-carry XOR rule.
  - sub=0 behaves exactly as the base block.
- When undefined:
  - No sub port. Addition only.
  - No extra logic on the B path.

Test Plan (WIDTH=16, DIGIT=4 unless stated):
1. a=0x1234, b=0x4321, cin=0, out_ready=1 → out_valid exactly 5 cycles after accept; sum=0x5555, cout=0, ovf=0; in_ready returns 1 on the cycle after the handshake.
2. a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, cout=1, ovf=0. Also a=0x7FFF, b=0x0001, cin=0 → sum=0x8000, cout=0, ovf=1.
3. Backpressure: hold out_ready=0 for 10 cycles after out_valid → sum, cout, ovf and out_valid stable throughout. Drive in_valid=1 with a different operand during RUN and DONE → ignored, in_ready stays 0.
4. Assert rst for 1 cycle during the 2nd RUN cycle of 0x00FF+0x0001 → all outputs at reset values immediately. A following op 0x0002+0x0003 yields 0x0005.
5. Parameter sweep DIGIT=1 and DIGIT=16 with a=0xA5A5, b=0x5A5B, cin=0 → sum=0x0000, cout=1, ovf=0; latency 17 and 2 cycles respectively.
6. With DIGIT_SERIAL_ADDER_SUB_EN defined and sub=1, a=0x0005, b=0x0007 → sum=0xFFFE, cout=0, ovf=0. With a=0x8000, b=0x0001 → sum=0x7FFF, cout=1, ovf=1.
